alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle multiply sequencer that drives the shared 12-bit ALU through its combinational port.
- Computes a 12x12 -> 24-bit product by shift-and-add, one ALU ADD per iteration; the shift is done locally.
- Sits between the control unit and the ALU's a/b/carry/func inputs.
- While the block is busy it owns the ALU inputs; in IDLE it drives neutral values.

Parameters:
DATA_W, 12, operand width; must equal the ALU width; only 12 supported.
DONE_HOLD, 0, 0: done_out is a 1-cycle pulse; 1: done_out held high until the next accepted start or reset.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start_in  in  1  request; accepted only when busy_out=0.
a_in  in  12  multiplicand, latched on accept.
b_in  in  12  multiplier, latched on accept.
busy_out  out  1  high from the cycle after accept through the DONE cycle.
done_out  out  1  product valid (see DONE_HOLD).
product_out  out  24  result; holds its value until the next done.
alu_a  out  12  to ALU a_in.
alu_b  out  12  to ALU b_in.
alu_cin  out  1  to ALU carry_in.
alu_func  out  3  to ALU func_code; ADD/SUB encodings are the `ADD/`SUB macros of src/instructions.sv.
alu_res  in  12  from ALU a_out.
alu_cout  in  1  from ALU carry_out (borrow for SUB).

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy_out=0; done_out=0; product_out=0; internal acc/mq/mcand/count=0; alu_a=alu_b=0; alu_cin=0; alu_func=`ADD.
- Reset mid-operation aborts with no done and returns all outputs to the reset values.
- IDLE: on start_in=1, latch mcand<=a_in, mq<=b_in, acc<=0, count<=0; go to ITER (or NEGA when MUL_SIGNED_EN).
- ITER (exactly 12 cycles, count 0..11):
  - alu_func=`ADD, alu_a=acc, alu_b = mq[0] ? mcand : 0, alu_cin=0.
  - Register update: {acc,mq} <= {alu_cout, alu_res, mq[11:1]}.
  - After count==11: go to DONE.
- DONE (1 cycle): product_out <= {acc,mq} is written on entry, so it is valid in this cycle. done_out=1, busy_out=1; next state IDLE.
- Unsigned latency: accept at edge 0; ITER on cycles 1-12; done_out high in cycle 13. Throughput is one multiply per 14 cycles.
- start_in while busy_out=1 is ignored and not queued.
- start_in in the DONE cycle is ignored.
- start_in in the first IDLE cycle after DONE is accepted.
- a_in/b_in changes after accept have no effect.
- DONE_HOLD=1: done_out stays 1 through IDLE; it clears on the edge that accepts a new start.
- Outside ITER and the signed states, ALU outputs return to the neutral values (0, 0, 0, `ADD).

Optional Feature:
MUL_SIGNED_EN
- Defined: adds port signed_in (in, 1), latched on accept. When signed_in=1, operands are two's complement and the product is the 24-bit two's complement result.
  - NEGA: if a[11], mcand <= ALU SUB (alu_a=0, alu_b=mcand, cin=0) result; else hold.
  - NEGB: the same operation applied to mq using b[11].
  - 12 ITER cycles as above.
  - NEGLO: if sign (a[11]^b[11]), mq <= 0 - mq via SUB, cin=0, and latch borrow.
  - NEGHI: if sign, acc <= 0 - acc - borrow via SUB, cin=borrow.
  - DONE.
  - The signed states take their cycle even when no negation is needed. Latency is fixed at 17 (done in cycle 17).
  - signed_in=0 skips NEGA/NEGB/NEGLO/NEGHI (latency 13).
  - -2048 magnitude is handled as unsigned 0x800.
- Undefined: no signed_in port; unsigned only; state encoding has no signed states.

Test Plan:
- Reset, then a_in=3, b_in=5, start pulse -> busy_out=1 cycles 1-13; done_out=1 in cycle 13; product_out=0x00000F; ALU func=`ADD during ITER.
- a_in=0xFFF, b_in=0xFFF -> product_out=0xFFE001 at cycle 13; a_in=0, b_in=0xABC -> product_out=0x000000.
- Start accepted, then start_in=1 with new operands at cycles 4 and 13 -> both ignored; first result returned unchanged; new start accepted at cycle 14 returns the new product at cycle 27.
- rst_n low at cycle 6 of an operation -> done_out never pulses; product_out=0 and busy_out=0 immediately (asynchronous); next start completes normally.
- DONE_HOLD=1: done_out stays 1 after completion until the next start edge, then drops.
- MUL_SIGNED_EN, signed_in=1:
  - -3 (0xFFD) x 5 -> 0xFFFFF1 in cycle 17.
  - -2048 x -2048 -> 0x400000.
  - -2048 x 1 -> 0xFFF800.
  - signed_in=0 with 0xFFD x 5 -> 0x004FF1 in cycle 13.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Shift-and-add 12x12 multiply sequencer driving the shared ALU combinationally.
// Optional two's complement mode when MUL_SIGNED_EN is defined (adds signed_in).
`ifndef ADD
`define ADD 3'b000
`endif
`ifndef SUB
`define SUB 3'b001
`endif

module alu_mul_seq #(
    parameter int DATA_W    = 12,
    parameter int DONE_HOLD = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_in,
    input  logic [DATA_W-1:0]   a_in,
    input  logic [DATA_W-1:0]   b_in,
`ifdef MUL_SIGNED_EN
    input  logic                signed_in,
`endif
    output logic                busy_out,
    output logic                done_out,
    output logic [2*DATA_W-1:0] product_out,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic                alu_cin,
    output logic [2:0]          alu_func,
    input  logic [DATA_W-1:0]   alu_res,
    input  logic                alu_cout
);

`ifdef MUL_SIGNED_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ITER, S_DONE, S_NEGA, S_NEGB, S_NEGLO, S_NEGHI
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_ITER, S_DONE
    } state_e;
`endif

    localparam logic [3:0] LAST = 4'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   mq_q, mq_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [3:0]          count_q, count_d;
    logic [2*DATA_W-1:0] product_q, product_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef MUL_SIGNED_EN
    logic                sgn_q, sgn_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic                borrow_q, borrow_d;
    logic                neg;
    assign neg = sa_q ^ sb_q;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = done_q;
        alu_a     = '0;
        alu_b     = '0;
        alu_cin   = 1'b0;
        alu_func  = `ADD;
`ifdef MUL_SIGNED_EN
        sgn_d     = sgn_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        borrow_d  = borrow_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    mcand_d = a_in;
                    mq_d    = b_in;
                    acc_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_ITER;
`ifdef MUL_SIGNED_EN
                    sgn_d    = signed_in;
                    sa_d     = signed_in & a_in[DATA_W-1];
                    sb_d     = signed_in & b_in[DATA_W-1];
                    borrow_d = 1'b0;
                    if (signed_in) state_d = S_NEGA;
`endif
                end
            end
            S_ITER: begin
                alu_a   = acc_q;
                alu_b   = mq_q[0] ? mcand_q : '0;
                {acc_d, mq_d} = {alu_cout, alu_res, mq_q[DATA_W-1:1]};
                count_d = count_q + 4'd1;
                if (count_q == LAST) begin
                    // Product is captured on the edge that enters DONE
                    product_d = {alu_cout, alu_res, mq_q[DATA_W-1:1]};
                    done_d    = 1'b1;
                    state_d   = S_DONE;
`ifdef MUL_SIGNED_EN
                    if (sgn_q) begin
                        product_d = product_q;
                        done_d    = 1'b0;
                        state_d   = S_NEGLO;
                    end
`endif
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = (DONE_HOLD != 0);
                state_d = S_IDLE;
            end
`ifdef MUL_SIGNED_EN
            S_NEGA: begin
                alu_func = `SUB;
                alu_b    = mcand_q;
                if (sa_q) mcand_d = alu_res;
                state_d  = S_NEGB;
            end
            S_NEGB: begin
                alu_func = `SUB;
                alu_b    = mq_q;
                if (sb_q) mq_d = alu_res;
                state_d  = S_ITER;
            end
            S_NEGLO: begin
                alu_func = `SUB;
                alu_b    = mq_q;
                if (neg) mq_d = alu_res;
                borrow_d = neg & alu_cout;
                state_d  = S_NEGHI;
            end
            S_NEGHI: begin
                alu_func  = `SUB;
                alu_b     = acc_q;
                alu_cin   = borrow_q;
                product_d = {neg ? alu_res : acc_q, mq_q};
                done_d    = 1'b1;
                state_d   = S_DONE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MUL_SIGNED_EN
            sgn_q     <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            borrow_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MUL_SIGNED_EN
            sgn_q     <= sgn_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            borrow_q  <= borrow_d;
`endif
        end
    end

    assign busy_out    = busy_q;
    assign done_out    = done_q;
    assign product_out = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: pulse (DONE_HOLD=0) and held (DONE_HOLD=1)
// instances run side by side, each with its own behavioural ALU.
`ifndef ADD
`define ADD 3'b000
`endif
`ifndef SUB
`define SUB 3'b001
`endif

module tb_alu_mul_seq;

    typedef struct {
        logic [23:0] prod;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] a_in = '0;
    logic [11:0] b_in = '0;
`ifdef MUL_SIGNED_EN
    logic        signed_in = 1'b0;
`endif

    logic        busy0, done0, cin0, cout0;
    logic [23:0] prod0;
    logic [11:0] a0, b0, res0;
    logic [2:0]  func0;
    logic        busy1, done1, cin1, cout1;
    logic [23:0] prod1;
    logic [11:0] a1, b1, res1;
    logic [2:0]  func1;

    int   cyc = 0;
    int   checks = 0;
    int   errs = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] alu_f(input logic [2:0] f,
                                          input logic [11:0] a,
                                          input logic [11:0] b,
                                          input logic c);
        if (f == `SUB) return {1'b0, a} - {1'b0, b} - {12'd0, c};
        return {1'b0, a} + {1'b0, b} + {12'd0, c};
    endfunction

    assign {cout0, res0} = alu_f(func0, a0, b0, cin0);
    assign {cout1, res1} = alu_f(func1, a1, b1, cin1);

    alu_mul_seq #(.DATA_W(12), .DONE_HOLD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_in(start),
        .a_in(a_in), .b_in(b_in),
`ifdef MUL_SIGNED_EN
        .signed_in(signed_in),
`endif
        .busy_out(busy0), .done_out(done0), .product_out(prod0),
        .alu_a(a0), .alu_b(b0), .alu_cin(cin0), .alu_func(func0),
        .alu_res(res0), .alu_cout(cout0)
    );

    alu_mul_seq #(.DATA_W(12), .DONE_HOLD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_in(start),
        .a_in(a_in), .b_in(b_in),
`ifdef MUL_SIGNED_EN
        .signed_in(signed_in),
`endif
        .busy_out(busy1), .done_out(done1), .product_out(prod1),
        .alu_a(a1), .alu_b(b1), .alu_cin(cin1), .alu_func(func1),
        .alu_res(res1), .alu_cout(cout1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model(input logic [11:0] a,
                                          input logic [11:0] b,
                                          input logic s);
        int sa, sb;
        if (s) begin
            sa = a[11] ? int'(a) - 4096 : int'(a);
            sb = b[11] ? int'(b) - 4096 : int'(b);
            return 24'(sa * sb);
        end
        return {12'd0, a} * {12'd0, b};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done0) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", sb_q.size(), 1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("product", prod0, e.prod);
                chk("prod_hold", prod1, e.prod);
                chk("latency", cyc - e.acc + 1, e.lat);
            end
        end
    end

    // Called at a negedge while idle; returns at the negedge after accept.
    task automatic go(input logic [11:0] a, input logic [11:0] b,
                      input logic s);
        exp_t e;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
`ifdef MUL_SIGNED_EN
        signed_in = s;
`endif
        @(posedge clk);
        #1;
        e.prod = model(a, b, s);
        e.acc  = cyc;
        e.lat  = s ? 17 : 13;
        sb_q.push_back(e);
        start = 1'b0;
        a_in  = 12'($urandom);
        b_in  = 12'($urandom);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || sb_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            chk("drain", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic run(input logic [11:0] a, input logic [11:0] b,
                       input logic s);
        wait_idle();
        go(a, b, s);
        wait_idle();
    endtask

    initial begin
        int nb;
        repeat (2) @(negedge clk);
        chk("rst_busy", {busy0, busy1}, 0);
        chk("rst_done", {done0, done1}, 0);
        chk("rst_prod", prod0, 0);
        chk("rst_alu", {a0, b0, cin0, func0}, {25'd0, `ADD});
        rst_n = 1'b1;
        @(negedge clk);

        // 3 x 5 with cycle-level observation
        go(12'd3, 12'd5, 1'b0);
        nb = busy0;
        chk("iter_b", b0, 12'd3);
        for (int k = 2; k <= 14; k++) begin
            @(negedge clk);
            if (k <= 13) nb += busy0;
            if (k == 5) chk("iter_func", func0, `ADD);
            if (k == 14) begin
                chk("busy_cnt", nb, 13);
                chk("idle_busy", busy0, 0);
                chk("idle_alu", {a0, b0, cin0, func0}, {25'd0, `ADD});
                chk("pulse_done", done0, 0);
                chk("hold_done", done1, 1);
            end
        end

        go(12'hFFF, 12'hFFF, 1'b0);
        chk("hold_clear", done1, 0);
        wait_idle();
        run(12'h000, 12'hABC, 1'b0);

        // Starts during busy and in DONE are dropped
        wait_idle();
        go(12'h123, 12'h456, 1'b0);
        for (int k = 2; k <= 14; k++) begin
            @(negedge clk);
            start = (k == 4 || k == 13);
            a_in  = 12'd7;
            b_in  = 12'd9;
        end
        go(12'h0AB, 12'h0CD, 1'b0);
        wait_idle();

        // Asynchronous abort in cycle 6
        go(12'h0AA, 12'h055, 1'b0);
        repeat (5) @(negedge clk);
        sb_q.delete();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy0, 0);
        chk("abort_prod", prod0, 0);
        chk("abort_done", {done0, done1}, 0);
        chk("abort_alu", {a0, b0, cin0, func0}, {25'd0, `ADD});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(negedge clk);
        chk("abort_nodone", {done0, busy0}, 0);
        run(12'h0AA, 12'h055, 1'b0);

        for (int i = 0; i < 6; i++)
            run(12'($urandom), 12'($urandom), 1'b0);

`ifdef MUL_SIGNED_EN
        run(12'hFFD, 12'd5, 1'b1);
        run(12'h800, 12'h800, 1'b1);
        run(12'h800, 12'd1, 1'b1);
        run(12'hFFD, 12'd5, 1'b0);
        for (int i = 0; i < 4; i++)
            run(12'($urandom), 12'($urandom), 1'b1);
`endif

        wait_idle();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
